pipe_skid_reg: RTL and testbench

//  Parametrised elastic pipeline register between processor stages (e.g. IF/ID, ID/EX).
//  Per-bit WIDTH-wide replacement for single-bit flops, with valid/ready handshake, stall

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_data_reg.sv | 15 +
 rtl/pipe_skid_reg.sv | 103 ++++++++++
 tb/tb_pipe_skid_reg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the elastic pipeline register: FSM states and the RISC-V NOP bubble.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [31:0] RV_NOP = 32'h00000013;

  // The state encoding doubles as the occupancy count.
  function automatic logic [1:0] state_count(input state_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-wide enabled D register; payload only, so deliberately left without reset.
module pipe_data_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (en) q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready pipeline register with optional 2-entry skid buffer and sync flush.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(RV_NOP),
  parameter bit               SKID       = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  state_t           state;
  logic             acc;
  logic             take;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_data_p1;
  logic [WIDTH-1:0] skid_data_p1;

  assign out_valid = (state != ST_EMPTY);
  assign take      = out_valid & out_ready;
  assign acc       = in_valid & in_ready & ~flush;

  generate
    if (SKID) begin : g_ready_reg
      // Decoded from state flops only, so the upstream ready path is cut here.
      assign in_ready = (state != ST_TWO);
    end else begin : g_ready_comb
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  always_comb begin
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    unique case (state)
      ST_EMPTY: main_en = acc;
      ST_ONE: begin
        main_en = acc & take;
        skid_en = acc & ~take;
      end
      ST_TWO: begin
        main_en = take;
        main_d  = skid_data_p1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: if (acc) state <= ST_ONE;
        ST_ONE: begin
          if (acc && !take && SKID) state <= ST_TWO;
          else if (take && !acc)    state <= ST_EMPTY;
        end
        ST_TWO: if (take) state <= ST_ONE;
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // ---- stage p1: payload entries (main is always older than skid) ----
  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .en  (main_en),
    .d   (main_d),
    .q   (main_data_p1)
  );

  generate
    if (SKID) begin : g_skid
      pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
        .clk (clk),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_data_p1)
      );
    end else begin : g_no_skid
      assign skid_data_p1 = BUBBLE_VAL;
    end
  endgenerate

  assign out_data = out_valid ? main_data_p1 : BUBBLE_VAL;
  assign count    = state_count(state);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: vector table, hand sequences and a scoreboard over SKID=1 and SKID=0.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] in_data = '0, out_data;
  logic [1:0]  count;

  logic        z_in_valid = 1'b0, z_in_ready, z_out_valid, z_out_ready = 1'b0;
  logic [31:0] z_in_data = '0, z_out_data;
  logic [1:0]  z_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit sb_en   = 1'b0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];

  always #5 clk = ~clk;

  pipe_skid_reg dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  pipe_skid_reg #(.SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
    .count(z_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic underflow(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: output beat with empty scoreboard, got data %h expected none at %0t",
             name, (name == "sb1") ? out_data : z_out_data, $time);
  endtask

  // Scoreboard monitor: samples 1 time unit before each rising edge.
  logic ir_after;
  always begin
    logic [31:0] exp;
    @(posedge clk);
    #1 ir_after = in_ready;
    @(negedge clk);
    #4;
    if (sb_en) begin
      chk("ir_stable", in_ready, ir_after);
      if (!out_valid)   chk("bubble1", out_data, 32'h13);
      if (!z_out_valid) chk("bubble0", z_out_data, 32'h13);
      if (out_valid && out_ready) begin
        if (q1.size() == 0) underflow("sb1");
        else begin exp = q1.pop_front(); chk("sb1_data", out_data, exp); end
      end
      if (z_out_valid && z_out_ready) begin
        if (q0.size() == 0) underflow("sb0");
        else begin exp = q0.pop_front(); chk("sb0_data", z_out_data, exp); end
      end
      if (rst || flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (in_valid && in_ready)     q1.push_back(in_data);
        if (z_in_valid && z_in_ready) q0.push_back(z_in_data);
      end
    end
  end

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  ec;
    logic        eir;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit f, input bit v, input logic [31:0] d,
                              input bit o, input bit ev, input logic [31:0] ed,
                              input logic [1:0] ec, input bit eir);
    vec_t t;
    t.rst = r; t.flush = f; t.iv = v; t.d = d; t.ordy = o;
    t.ev = ev; t.ed = ed; t.ec = ec; t.eir = eir;
    return t;
  endfunction

  vec_t tbl[16];

  initial begin
    // reset held two cycles with a beat offered
    tbl[0]  = mk(1, 0, 1, 32'hEE, 0,  0, 32'h13, 0, 1);
    tbl[1]  = mk(1, 0, 1, 32'hEE, 0,  0, 32'h13, 0, 1);
    tbl[2]  = mk(0, 0, 0, 32'h00, 0,  0, 32'h13, 0, 1);
    // stall into skid, then drain in order
    tbl[3]  = mk(0, 0, 1, 32'h11, 0,  1, 32'h11, 1, 1);
    tbl[4]  = mk(0, 0, 1, 32'h22, 0,  1, 32'h11, 2, 0);
    tbl[5]  = mk(0, 0, 0, 32'h00, 1,  1, 32'h22, 1, 1);
    tbl[6]  = mk(0, 0, 0, 32'h00, 1,  0, 32'h13, 0, 1);
    // flush while full with a beat offered
    tbl[7]  = mk(0, 0, 1, 32'h33, 0,  1, 32'h33, 1, 1);
    tbl[8]  = mk(0, 0, 1, 32'h44, 0,  1, 32'h33, 2, 0);
    tbl[9]  = mk(0, 1, 1, 32'h55, 0,  0, 32'h13, 0, 1);
    tbl[10] = mk(0, 0, 0, 32'h00, 1,  0, 32'h13, 0, 1);
    // flush coinciding with a take
    tbl[11] = mk(0, 0, 1, 32'h66, 1,  1, 32'h66, 1, 1);
    tbl[12] = mk(0, 1, 1, 32'h77, 1,  0, 32'h13, 0, 1);
    // reset mid-transfer
    tbl[13] = mk(0, 0, 1, 32'h88, 0,  1, 32'h88, 1, 1);
    tbl[14] = mk(1, 0, 1, 32'h99, 0,  0, 32'h13, 0, 1);
    tbl[15] = mk(0, 0, 0, 32'h00, 0,  0, 32'h13, 0, 1);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; flush = tbl[i].flush; in_valid = tbl[i].iv;
      in_data = tbl[i].d; out_ready = tbl[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].ed);
      chk($sformatf("vec%0d_count", i), count, tbl[i].ec);
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].eir);
    end
    chk("skid0_reset_valid", z_out_valid, 1'b0);
    chk("skid0_reset_data", z_out_data, 32'h13);

    // streaming at full throughput
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sb_en = 1'b1; in_valid = 1'b1; in_data = 32'hA0 + i; out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_data", out_data, 32'hA0 + i);
      chk("stream_count", count, 2'd1);
      chk("stream_in_ready", in_ready, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("stream_drained", out_valid, 1'b0);

    // SKID=0: combinational ready and replace-on-take
    @(negedge clk);
    z_in_valid = 1'b1; z_in_data = 32'h66; z_out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("z_hold_data", z_out_data, 32'h66);
    chk("z_hold_count", z_count, 2'd1);
    @(negedge clk);
    z_in_valid = 1'b0;
    #1 chk("z_ready_low", z_in_ready, 1'b0);
    z_out_ready = 1'b1;
    #1 chk("z_ready_comb_high", z_in_ready, 1'b1);
    z_in_valid = 1'b1; z_in_data = 32'h77;
    @(posedge clk);
    #1;
    chk("z_replace_data", z_out_data, 32'h77);
    chk("z_replace_count", z_count, 2'd1);
    @(negedge clk);
    z_in_valid = 1'b0; z_out_ready = 1'b0;
    #1 chk("z_ready_track_low", z_in_ready, 1'b0);
    z_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("z_empty_valid", z_out_valid, 1'b0);
    chk("z_empty_ready", z_in_ready, 1'b1);

    // random valid/ready with occasional flush on both variants
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = $urandom;
      out_ready   = ($urandom_range(0, 2) != 0);
      z_in_valid  = ($urandom_range(0, 3) != 0);
      z_in_data   = $urandom;
      z_out_ready = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; z_in_valid = 1'b0;
    out_ready = 1'b1; z_out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("drain_q1", q1.size(), 0);
    chk("drain_q0", q0.size(), 0);
    chk("drain_valid1", out_valid, 1'b0);
    chk("drain_valid0", z_out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
